// File: rtl/io_bus_arbiter_pkg.sv
// Shared types, widths and address-field positions for the peripheral IO bus arbiter.
package io_bus_pkg;

  // Bus phase of the arbiter FSM
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int IO_IDX_W  = 5;
  localparam int IO_REG_W  = 4;
  localparam int IO_DATA_W = 32;
  localparam int IO_ADDR_W = IO_IDX_W + IO_REG_W;

  // Requester address layout: {io_index[8:4], reg_addr[3:0]}
  localparam int ADDR_REG_LSB = 0;
  localparam int ADDR_REG_MSB = ADDR_REG_LSB + IO_REG_W - 1;
  localparam int ADDR_IDX_LSB = ADDR_REG_MSB + 1;
  localparam int ADDR_IDX_MSB = ADDR_IDX_LSB + IO_IDX_W - 1;

  // Transaction captured from the winning requester when it is granted
  typedef struct packed {
    logic                 wr;
    logic [IO_IDX_W-1:0]  idx;
    logic [IO_REG_W-1:0]  reg_addr;
    logic [IO_DATA_W-1:0] wdata;
  } txn_t;

  // True when the peripheral index names an existing chip select
  function automatic logic idx_in_range(input logic [IO_IDX_W-1:0] idx, input int ionum);
    return int'(idx) < ionum;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or above the pointer,
// wrapping to the lowest requester overall when none is above it.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  logic [NREQ-1:0] upper_mask;
  logic [NREQ-1:0] upper_req;
  logic [NREQ-1:0] pick_vec;

  // Requesters at or after the pointer have priority this round
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
    assign upper_mask[gi] = (IDX_W'(gi) >= rr);
  end

  assign upper_req = req & upper_mask;
  assign pick_vec  = (|upper_req) ? upper_req : req;
  // Isolate the lowest set bit of the candidate vector
  assign grant     = pick_vec & (~pick_vec + NREQ'(1));
  assign any_req   = |req;

  // Encode the one-hot grant into a binary index
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the peripheral IO bus between NREQ requesters: round-robin grant,
// then fixed SETUP / ACCESS x ACC_CYC / HOLD phases, read data and done pulse.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int IONUM   = 32,
  parameter int ACC_CYC = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_wr,
  input  logic [NREQ*IO_ADDR_W-1:0] req_addr,
  input  logic [NREQ*IO_DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]           done,
  output logic [NREQ-1:0]           err,
  output logic [IO_DATA_W-1:0]      rdata,
  output logic [IONUM-1:0]          io_cs_en,
  output logic [IO_REG_W-1:0]       io_reg_addr,
  output logic                      io_wt_en,
  output logic                      io_rd_en,
  output logic [IO_DATA_W-1:0]      io_wdata,
  output logic                      io_data_oe,
  input  logic [IO_DATA_W-1:0]      io_rdata
);

  localparam int          IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]  ACC_LAST = 4'(ACC_CYC - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  txn_t               txn_q, txn_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IO_DATA_W-1:0] rdata_q, rdata_d;

  logic [NREQ-1:0]    grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_req;
  logic               in_range;
  logic               active;

  logic [IO_ADDR_W-1:0] addr_arr  [NREQ];
  logic [IO_DATA_W-1:0] wdata_arr [NREQ];

  // Split the flat per-requester buses into indexable fields
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*IO_ADDR_W +: IO_ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*IO_DATA_W +: IO_DATA_W];
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req),
    .rr        (rr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign in_range = idx_in_range(txn_q.idx, IONUM);
  assign active   = (state_q != ST_IDLE);

  // Phase sequencing, transaction capture, read-data capture and pointer advance
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    txn_d   = txn_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          win_d          = grant_idx;
          txn_d.wr       = |(grant & req_wr);
          txn_d.idx      = addr_arr[grant_idx][ADDR_IDX_MSB:ADDR_IDX_LSB];
          txn_d.reg_addr = addr_arr[grant_idx][ADDR_REG_MSB:ADDR_REG_LSB];
          txn_d.wdata    = wdata_arr[grant_idx];
          state_d        = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == ACC_LAST) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
          // No peripheral answers an out-of-range select, so return zero
          if (!txn_q.wr) rdata_d = in_range ? io_rdata : '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HOLD: begin
        rr_d    = (int'(win_q) == NREQ - 1) ? '0 : win_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      txn_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      txn_q   <= txn_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus drive: address/data/oe across all non-idle phases, strobes only in ACCESS
  always_comb begin
    io_reg_addr = active ? txn_q.reg_addr : '0;
    io_wdata    = active ? txn_q.wdata : '0;
    io_data_oe  = active & txn_q.wr;
    io_wt_en    = (state_q == ST_ACCESS) & txn_q.wr;
    io_rd_en    = (state_q == ST_ACCESS) & ~txn_q.wr;
  end

  // One-hot chip select; an out-of-range index selects nothing
  for (genvar gi = 0; gi < IONUM; gi++) begin : g_cs
    assign io_cs_en[gi] = active & in_range & (txn_q.idx == IO_IDX_W'(gi));
  end

  // Completion pulses go only to the latched winner during HOLD
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_done
    assign done[gi] = (state_q == ST_HOLD) & (win_q == IDX_W'(gi));
    assign err[gi]  = (state_q == ST_HOLD) & (win_q == IDX_W'(gi)) & ~in_range;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench: table of single transactions, contention, ACC_CYC=3,
// reset mid-transaction, and randomized traffic against a transaction model.
module tb_io_bus_arbiter;

  localparam int A_N = 2, A_IONUM = 16, A_ACC = 1;
  localparam int B_N = 3, B_IONUM = 32, B_ACC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance A
  logic               a_rst_n;
  logic [A_N-1:0]     a_req, a_req_wr, a_done, a_err;
  logic [A_N*9-1:0]   a_req_addr;
  logic [A_N*32-1:0]  a_req_wdata;
  logic [31:0]        a_rdata, a_wdata, a_io_rdata;
  logic [A_IONUM-1:0] a_cs;
  logic [3:0]         a_reg;
  logic               a_wt, a_rd, a_oe;

  // Instance B
  logic               b_rst_n;
  logic [B_N-1:0]     b_req, b_req_wr, b_done, b_err;
  logic [B_N*9-1:0]   b_req_addr;
  logic [B_N*32-1:0]  b_req_wdata;
  logic [31:0]        b_rdata, b_wdata, b_io_rdata;
  logic [B_IONUM-1:0] b_cs;
  logic [3:0]         b_reg;
  logic               b_wt, b_rd, b_oe;

  io_bus_arbiter #(.NREQ(A_N), .IONUM(A_IONUM), .ACC_CYC(A_ACC)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .req(a_req), .req_wr(a_req_wr), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .done(a_done), .err(a_err), .rdata(a_rdata),
    .io_cs_en(a_cs), .io_reg_addr(a_reg), .io_wt_en(a_wt), .io_rd_en(a_rd),
    .io_wdata(a_wdata), .io_data_oe(a_oe), .io_rdata(a_io_rdata)
  );

  io_bus_arbiter #(.NREQ(B_N), .IONUM(B_IONUM), .ACC_CYC(B_ACC)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .req(b_req), .req_wr(b_req_wr), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .done(b_done), .err(b_err), .rdata(b_rdata),
    .io_cs_en(b_cs), .io_reg_addr(b_reg), .io_wt_en(b_wt), .io_rd_en(b_rd),
    .io_wdata(b_wdata), .io_data_oe(b_oe), .io_rdata(b_io_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, " a cs"}, a_cs, 0);     chk({tag, " a reg"}, a_reg, 0);
    chk({tag, " a wt"}, a_wt, 0);     chk({tag, " a rd"}, a_rd, 0);
    chk({tag, " a oe"}, a_oe, 0);     chk({tag, " a wdata"}, a_wdata, 0);
    chk({tag, " a done"}, a_done, 0); chk({tag, " a err"}, a_err, 0);
    chk({tag, " a rdata"}, a_rdata, 0);
  endtask

  task automatic chk_b_zero(input string tag);
    chk({tag, " b cs"}, b_cs, 0);     chk({tag, " b reg"}, b_reg, 0);
    chk({tag, " b wt"}, b_wt, 0);     chk({tag, " b rd"}, b_rd, 0);
    chk({tag, " b oe"}, b_oe, 0);     chk({tag, " b wdata"}, b_wdata, 0);
    chk({tag, " b done"}, b_done, 0); chk({tag, " b err"}, b_err, 0);
    chk({tag, " b rdata"}, b_rdata, 0);
  endtask

  typedef struct {
    int          r;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdin;
    logic [15:0] exp_cs;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  // One isolated transaction on A, checked every cycle from SETUP to the following IDLE
  task automatic do_vec(input vec_t v, input int n);
    string tg;
    tg = $sformatf("vec%0d", n);
    a_req_wr[v.r] = v.wr;
    a_req_addr[v.r*9 +: 9] = v.addr;
    a_req_wdata[v.r*32 +: 32] = v.wdata;
    a_io_rdata = v.rdin;
    a_req[v.r] = 1'b1;
    chk({tg, " idle cs"}, a_cs, 0);
    chk({tg, " idle oe"}, a_oe, 0);
    for (int t = 1; t <= 2 + A_ACC; t++) begin
      @(negedge clk);
      chk($sformatf("%s t%0d cs", tg, t), a_cs, v.exp_cs);
      chk($sformatf("%s t%0d reg", tg, t), a_reg, v.addr[3:0]);
      chk($sformatf("%s t%0d wdata", tg, t), a_wdata, v.wdata);
      chk($sformatf("%s t%0d oe", tg, t), a_oe, v.wr);
      chk($sformatf("%s t%0d wt", tg, t), a_wt, v.wr && t >= 2 && t <= 1 + A_ACC);
      chk($sformatf("%s t%0d rd", tg, t), a_rd, !v.wr && t >= 2 && t <= 1 + A_ACC);
      chk($sformatf("%s t%0d done", tg, t), a_done, (t == 2 + A_ACC) ? (1 << v.r) : 0);
      chk($sformatf("%s t%0d err", tg, t), a_err, (t == 2 + A_ACC && v.exp_err) ? (1 << v.r) : 0);
      if (t == 1) begin
        a_req_wdata[v.r*32 +: 32] = ~v.wdata;
        a_req_addr[v.r*9 +: 9] = ~v.addr;
        a_req_wr[v.r] = ~v.wr;
      end
      if (t == 2 + A_ACC) begin
        chk({tg, " rdata at done"}, a_rdata, v.exp_rdata);
        a_req[v.r] = 1'b0;
      end
    end
    @(negedge clk);
    chk({tg, " after done"}, a_done, 0);
    chk({tg, " after cs"}, a_cs, 0);
    chk({tg, " rdata held"}, a_rdata, v.exp_rdata);
    $display("txn %s r=%0d wr=%0d idx=%0d reg=%0d rdata=%h", tg, v.r, v.wr, v.addr[8:4], v.addr[3:0], a_rdata);
  endtask

  vec_t vecs[6];

  // Transaction-level reference model state for the random phase
  bit          m_busy;
  int          m_t, m_win, m_rr;
  logic        m_wr;
  logic [4:0]  m_idx;
  logic [3:0]  m_reg;
  logic [31:0] m_wd, m_rdata;

  initial begin
    int ord[8], cyc[8], n, strobes;
    logic [15:0] e_cs;
    bit found;

    a_rst_n = 0; a_req = 0; a_req_wr = 0; a_req_addr = 0; a_req_wdata = 0; a_io_rdata = 0;
    b_rst_n = 0; b_req = 0; b_req_wr = 0; b_req_addr = 0; b_req_wdata = 0; b_io_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_a_zero("reset");
    chk_b_zero("reset");
    a_rst_n = 1; b_rst_n = 1;

    // Single-transaction table on A (ACC_CYC=1, IONUM=16)
    vecs[0] = '{0, 1'b1, {5'd8, 4'd3},  32'hA5A5_0001, 32'h0000_DEAD, 16'h0100, 1'b0, 32'h0};
    vecs[1] = '{1, 1'b0, {5'd4, 4'd1},  32'h0,         32'h0000_1234, 16'h0010, 1'b0, 32'h1234};
    vecs[2] = '{1, 1'b1, {5'd15, 4'hF}, 32'hFFFF_0000, 32'h0000_BEEF, 16'h8000, 1'b0, 32'h1234};
    vecs[3] = '{0, 1'b0, {5'd31, 4'd2}, 32'h0,         32'h0000_CAFE, 16'h0000, 1'b1, 32'h0};
    vecs[4] = '{0, 1'b1, {5'd16, 4'd7}, 32'h1357_9BDF, 32'h0,         16'h0000, 1'b1, 32'h0};
    vecs[5] = '{1, 1'b0, {5'd0, 4'hA},  32'h0,         32'h8765_4321, 16'h0001, 1'b0, 32'h8765_4321};
    for (int i = 0; i < 6; i++) do_vec(vecs[i], i);

    // Contention on A: both requesters held, re-asserting the cycle after done
    a_rst_n = 0;
    @(negedge clk);
    chk_a_zero("reset2");
    a_rst_n = 1;
    a_req_wr = 2'b11;
    a_req_addr = {5'd2, 4'd0, 5'd1, 4'd0};
    n = 0;
    a_req = 2'b11;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      for (int i = 0; i < A_N; i++) begin
        if (a_done[i]) begin
          if (n < 8) begin ord[n] = i; cyc[n] = c; end
          n++;
          a_req[i] = 1'b0;
          $display("txn contention r=%0d cycle=%0d", i, c);
        end else begin
          a_req[i] = 1'b1;
        end
      end
    end
    a_req = 0;
    chk("contention done count", n, 4);
    if (n >= 4) begin
      chk("contention first done cycle", cyc[0], 3);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("contention order%0d", k), ord[k], k % 2);
        if (k > 0) chk($sformatf("contention spacing%0d", k), cyc[k] - cyc[k-1], 4);
      end
    end
    @(negedge clk);

    // B, ACC_CYC=3 write; req dropped early, req_wdata changed mid-ACCESS
    b_req_wr[1] = 1'b1;
    b_req_addr[9 +: 9] = {5'd2, 4'd5};
    b_req_wdata[32 +: 32] = 32'h1111_2222;
    b_req[1] = 1'b1;
    strobes = 0;
    for (int t = 1; t <= 2 + B_ACC; t++) begin
      @(negedge clk);
      chk($sformatf("acc3 t%0d cs", t), b_cs, 32'd4);
      chk($sformatf("acc3 t%0d reg", t), b_reg, 5);
      chk($sformatf("acc3 t%0d wdata", t), b_wdata, 32'h1111_2222);
      chk($sformatf("acc3 t%0d oe", t), b_oe, 1);
      chk($sformatf("acc3 t%0d rd", t), b_rd, 0);
      chk($sformatf("acc3 t%0d wt", t), b_wt, t >= 2 && t <= 1 + B_ACC);
      chk($sformatf("acc3 t%0d done", t), b_done, (t == 2 + B_ACC) ? 3'b010 : 3'b000);
      if (b_wt) strobes++;
      if (t == 2) b_req[1] = 1'b0;
      if (t == 3) b_req_wdata[32 +: 32] = 32'h9999_9999;
    end
    chk("acc3 strobe cycles", strobes, B_ACC);
    $display("txn acc3 write r=1 strobes=%0d", strobes);
    @(negedge clk);
    chk("acc3 after done", b_done, 0);
    chk("acc3 after oe", b_oe, 0);

    // B, reset during the 2nd ACCESS cycle of a read by requester 0 (rr is 2 here)
    b_req_wr[0] = 1'b0;
    b_req_addr[0 +: 9] = {5'd7, 4'd0};
    b_io_rdata = 32'h0000_5555;
    b_req[0] = 1'b1;
    for (int t = 1; t <= 3; t++) @(negedge clk);
    chk("rstmid rd before reset", b_rd, 1);
    chk("rstmid cs before reset", b_cs, 32'h80);
    b_rst_n = 0;
    @(negedge clk);
    chk_b_zero("rstmid");
    b_rst_n = 1;
    b_req = 3'b110;
    b_req_wr = 3'b000;
    b_req_addr = {5'd9, 4'd1, 5'd3, 4'd2, 9'd0};
    b_io_rdata = 32'h0000_ABCD;
    for (int t = 1; t <= 2 + B_ACC; t++) begin
      @(negedge clk);
      chk($sformatf("postrst t%0d cs", t), b_cs, 32'd8);
      chk($sformatf("postrst t%0d done", t), b_done, (t == 2 + B_ACC) ? 3'b010 : 3'b000);
      if (t == 2 + B_ACC) chk("postrst rdata", b_rdata, 32'h0000_ABCD);
    end
    b_req = 0;
    $display("txn postreset read r=1 rdata=%h", b_rdata);

    // Randomized traffic on A against the transaction model
    a_rst_n = 0;
    @(negedge clk);
    a_rst_n = 1;
    a_req = 0;
    m_busy = 0; m_t = 0; m_win = 0; m_rr = 0; m_rdata = 0;
    m_wr = 0; m_idx = 0; m_reg = 0; m_wd = 0;
    for (int cy = 0; cy < 600; cy++) begin
      e_cs = (m_busy && m_idx < A_IONUM) ? 16'(1 << m_idx) : 16'd0;
      chk("rnd cs", a_cs, e_cs);
      chk("rnd reg", a_reg, m_busy ? m_reg : 4'd0);
      chk("rnd wdata", a_wdata, m_busy ? m_wd : 32'd0);
      chk("rnd oe", a_oe, m_busy && m_wr);
      chk("rnd wt", a_wt, m_busy && m_wr && m_t >= 2 && m_t <= 1 + A_ACC);
      chk("rnd rd", a_rd, m_busy && !m_wr && m_t >= 2 && m_t <= 1 + A_ACC);
      chk("rnd done", a_done, (m_busy && m_t == 2 + A_ACC) ? (1 << m_win) : 0);
      chk("rnd err", a_err, (m_busy && m_t == 2 + A_ACC && m_idx >= A_IONUM) ? (1 << m_win) : 0);
      chk("rnd rdata", a_rdata, m_rdata);
      chk("rnd strobe exclusive", a_wt & a_rd, 0);
      if (m_busy && m_t == 2 + A_ACC)
        $display("txn rnd r=%0d wr=%0d idx=%0d rdata=%h", m_win, m_wr, m_idx, m_rdata);
      for (int i = 0; i < A_N; i++) begin
        if (m_busy && m_t == 2 + A_ACC && m_win == i) a_req[i] = 1'b0;
        else if (!a_req[i] && cy < 580 && $urandom_range(0, 2) == 0) a_req[i] = 1'b1;
        a_req_wr[i] = 1'($urandom);
        a_req_addr[i*9 +: 9] = 9'($urandom);
        a_req_wdata[i*32 +: 32] = $urandom;
      end
      a_io_rdata = $urandom;
      @(posedge clk);
      if (!m_busy) begin
        found = 0;
        for (int k = 0; k < A_N; k++) begin
          if (!found && a_req[(m_rr + k) % A_N]) begin
            found = 1;
            m_win = (m_rr + k) % A_N;
          end
        end
        if (found) begin
          m_busy = 1; m_t = 1;
          m_wr  = a_req_wr[m_win];
          m_idx = a_req_addr[m_win*9 + 4 +: 5];
          m_reg = a_req_addr[m_win*9 +: 4];
          m_wd  = a_req_wdata[m_win*32 +: 32];
        end
      end else begin
        if (m_t == 1 + A_ACC && !m_wr) m_rdata = (m_idx < A_IONUM) ? a_io_rdata : 32'd0;
        if (m_t == 2 + A_ACC) begin
          m_busy = 0; m_t = 0; m_rr = (m_win + 1) % A_N;
        end else begin
          m_t++;
        end
      end
      @(negedge clk);
    end
    chk("rnd drained", m_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
